// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard interface: decode/pipeline control drives the master side,
// the hazard scoreboard sits on the slave side.
interface hazard_scoreboard_if #(
  parameter int ADDR_W    = 5,
  parameter int FWD_DEPTH = 3
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic                 dec_valid_i;
  logic [ADDR_W-1:0]    dec_rs0_i;
  logic [ADDR_W-1:0]    dec_rs1_i;
  logic                 dec_use_rs0_i;
  logic                 dec_use_rs1_i;
  logic                 dec_rf_we_i;
  logic [ADDR_W-1:0]    dec_waddr_i;
  logic                 dec_is_load_i;
  logic                 redirect_i;
  logic                 stall_o;
  logic                 flush_o;
  logic [SEL_W-1:0]     fwd_sel0_o;
  logic [SEL_W-1:0]     fwd_sel1_o;
  logic [FWD_DEPTH-1:0] inflight_o;

  modport master (
    output dec_valid_i, dec_rs0_i, dec_rs1_i, dec_use_rs0_i, dec_use_rs1_i,
           dec_rf_we_i, dec_waddr_i, dec_is_load_i, redirect_i,
    input  stall_o, flush_o, fwd_sel0_o, fwd_sel1_o, inflight_o
  );

  modport slave (
    input  dec_valid_i, dec_rs0_i, dec_rs1_i, dec_use_rs0_i, dec_use_rs1_i,
           dec_rf_we_i, dec_waddr_i, dec_is_load_i, redirect_i,
    output stall_o, flush_o, fwd_sel0_o, fwd_sel1_o, inflight_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard producing forwarding selects, load-use stall and redirect flush.
// Optional stall/flush counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_READY = 1,
  parameter int BR_STAGE   = 1
) (
  input  logic               clk,
  input  logic               reset,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o,
`endif
  hazard_scoreboard_if.slave sb
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] waddr;
    logic              is_load;
  } entry_t;

  entry_t           sb_q [FWD_DEPTH];
  entry_t           sb_d [FWD_DEPTH];
  logic [SEL_W-1:0] sel0, sel1;
  logic             late0, late1;
  logic             stall, flush, issue;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel0  = '0;
    sel1  = '0;
    late0 = 1'b0;
    late1 = 1'b0;
    for (int unsigned k = FWD_DEPTH; k > 0; k--) begin
      if (sb.dec_use_rs0_i && sb_q[k-1].valid && sb.dec_rs0_i != '0 &&
          sb_q[k-1].waddr == sb.dec_rs0_i) begin
        sel0  = SEL_W'(k);
        late0 = sb_q[k-1].is_load && ((k - 1) < LOAD_READY);
      end
      if (sb.dec_use_rs1_i && sb_q[k-1].valid && sb.dec_rs1_i != '0 &&
          sb_q[k-1].waddr == sb.dec_rs1_i) begin
        sel1  = SEL_W'(k);
        late1 = sb_q[k-1].is_load && ((k - 1) < LOAD_READY);
      end
    end
  end

  // Redirect beats stall; flush is held low while reset is asserted.
  always_comb begin
    stall = (late0 | late1) & ~sb.redirect_i;
    flush = sb.redirect_i & reset;
    issue = sb.dec_valid_i & ~stall & ~sb.redirect_i;
  end

  always_comb begin
    sb_d[0] = '0;
    if (issue) begin
      sb_d[0].valid   = sb.dec_rf_we_i && (sb.dec_waddr_i != '0);
      sb_d[0].waddr   = sb.dec_waddr_i;
      sb_d[0].is_load = sb.dec_is_load_i;
    end
    for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
      if (sb.redirect_i && ((k - 1) < BR_STAGE))
        sb_d[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < FWD_DEPTH; k++)
        sb_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < FWD_DEPTH; k++)
        sb_q[k] <= sb_d[k];
    end
  end

  always_comb begin
    sb.stall_o    = stall;
    sb.flush_o    = flush;
    sb.fwd_sel0_o = sel0;
    sb.fwd_sel1_o = sel1;
    for (int unsigned k = 0; k < FWD_DEPTH; k++)
      sb.inflight_o[k] = sb_q[k].valid;
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  hazard_scoreboard_if #(.ADDR_W(5), .FWD_DEPTH(3)) intf ();

  hazard_scoreboard #(
    .ADDR_W(5), .FWD_DEPTH(3), .LOAD_READY(1), .BR_STAGE(1)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt),
`endif
    .sb(intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_dec(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic u0, input logic u1, input logic we,
                         input logic [4:0] wa, input logic ld);
    intf.dec_valid_i   = v;
    intf.dec_rs0_i     = rs0;
    intf.dec_rs1_i     = rs1;
    intf.dec_use_rs0_i = u0;
    intf.dec_use_rs1_i = u1;
    intf.dec_rf_we_i   = we;
    intf.dec_waddr_i   = wa;
    intf.dec_is_load_i = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    intf.redirect_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_dec(1, 5, 5, 1, 1, 1, 5, 1);
    intf.redirect_i = 1'b1;
    repeat (2) tick();
    #1;
    checks++;
    if (intf.flush_o !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", intf.flush_o); end
    checks++;
    if (intf.stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", intf.stall_o); end
    checks++;
    if (intf.inflight_o !== 3'b000) begin failures++; $display("FAIL reset_inflight got=%b exp=000", intf.inflight_o); end
    checks++;
    if (intf.fwd_sel0_o !== 2'd0 || intf.fwd_sel1_o !== 2'd0) begin
      failures++; $display("FAIL reset_sel got=%0d/%0d exp=0/0", intf.fwd_sel0_o, intf.fwd_sel1_o);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
`endif
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    intf.redirect_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu_chain();
    clear_pipe();
    set_dec(1, 0, 0, 0, 0, 1, 5, 0);
    tick();
    set_dec(1, 5, 5, 1, 1, 1, 6, 0);
    #1;
    checks++;
    if (intf.fwd_sel0_o !== 2'd1 || intf.fwd_sel1_o !== 2'd1) begin
      failures++; $display("FAIL alu_sel got=%0d/%0d exp=1/1", intf.fwd_sel0_o, intf.fwd_sel1_o);
    end
    checks++;
    if (intf.stall_o !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", intf.stall_o); end
    tick();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_dec(1, 5, 6, 1, 1, 0, 0, 0);
    #1;
    checks++;
    if (intf.fwd_sel0_o !== 2'd3 || intf.fwd_sel1_o !== 2'd2) begin
      failures++; $display("FAIL alu_far_sel got=%0d/%0d exp=3/2", intf.fwd_sel0_o, intf.fwd_sel1_o);
    end
    checks++;
    if (intf.inflight_o !== 3'b110) begin failures++; $display("FAIL alu_inflight got=%b exp=110", intf.inflight_o); end
  endtask

  task automatic test_youngest();
    clear_pipe();
    set_dec(1, 0, 0, 0, 0, 1, 9, 0);
    tick();
    set_dec(1, 0, 0, 0, 0, 1, 9, 0);
    tick();
    set_dec(1, 9, 9, 1, 1, 0, 0, 0);
    #1;
    checks++;
    if (intf.fwd_sel0_o !== 2'd1 || intf.fwd_sel1_o !== 2'd1) begin
      failures++; $display("FAIL youngest_sel got=%0d/%0d exp=1/1", intf.fwd_sel0_o, intf.fwd_sel1_o);
    end
    checks++;
    if (intf.inflight_o !== 3'b011) begin failures++; $display("FAIL youngest_inflight got=%b exp=011", intf.inflight_o); end
  endtask

  task automatic test_load_use();
    clear_pipe();
    set_dec(1, 0, 0, 0, 0, 1, 7, 1);
    tick();
    set_dec(1, 7, 1, 1, 1, 1, 8, 0);
    #1;
    checks++;
    if (intf.stall_o !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", intf.stall_o); end
    checks++;
    if (intf.fwd_sel1_o !== 2'd0) begin failures++; $display("FAIL lu_sel1 got=%0d exp=0", intf.fwd_sel1_o); end
    tick();
    #1;
    checks++;
    if (intf.stall_o !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", intf.stall_o); end
    checks++;
    if (intf.fwd_sel0_o !== 2'd2) begin failures++; $display("FAIL lu_sel0 got=%0d exp=2", intf.fwd_sel0_o); end
    checks++;
    if (intf.inflight_o !== 3'b010) begin failures++; $display("FAIL lu_bubble got=%b exp=010", intf.inflight_o); end
    tick();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (intf.inflight_o !== 3'b101) begin failures++; $display("FAIL lu_shift got=%b exp=101", intf.inflight_o); end
  endtask

  task automatic test_x0();
    clear_pipe();
    set_dec(1, 0, 0, 0, 0, 1, 0, 1);
    tick();
    set_dec(1, 0, 0, 1, 1, 0, 0, 0);
    #1;
    checks++;
    if (intf.inflight_o !== 3'b000) begin failures++; $display("FAIL x0_inflight got=%b exp=000", intf.inflight_o); end
    checks++;
    if (intf.fwd_sel0_o !== 2'd0 || intf.stall_o !== 1'b0) begin
      failures++; $display("FAIL x0_read got=sel%0d/stall%b exp=sel0/stall0", intf.fwd_sel0_o, intf.stall_o);
    end
  endtask

  task automatic test_redirect();
    clear_pipe();
    repeat (3) begin
      set_dec(1, 0, 0, 0, 0, 1, 3, 0);
      tick();
    end
    set_dec(1, 0, 0, 0, 0, 1, 4, 0);
    intf.redirect_i = 1'b1;
    #1;
    checks++;
    if (intf.flush_o !== 1'b1 || intf.stall_o !== 1'b0) begin
      failures++; $display("FAIL redir_out got=flush%b/stall%b exp=flush1/stall0", intf.flush_o, intf.stall_o);
    end
    checks++;
    if (intf.inflight_o !== 3'b111) begin failures++; $display("FAIL redir_pre got=%b exp=111", intf.inflight_o); end
    tick();
    set_dec(1, 3, 0, 1, 0, 0, 0, 0);
    #1;
    checks++;
    if (intf.inflight_o !== 3'b100) begin failures++; $display("FAIL redir_squash got=%b exp=100", intf.inflight_o); end
    checks++;
    if (intf.fwd_sel0_o !== 2'd3) begin failures++; $display("FAIL redir_sel got=%0d exp=3", intf.fwd_sel0_o); end
    checks++;
    if (intf.flush_o !== 1'b1) begin failures++; $display("FAIL redir_b2b got=%b exp=1", intf.flush_o); end
    tick();
    intf.redirect_i = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (intf.inflight_o !== 3'b000 || intf.flush_o !== 1'b0) begin
      failures++; $display("FAIL redir_after got=%b/flush%b exp=000/flush0", intf.inflight_o, intf.flush_o);
    end
  endtask

  task automatic test_redirect_stall();
    clear_pipe();
    set_dec(1, 0, 0, 0, 0, 1, 7, 1);
    tick();
    set_dec(1, 7, 0, 1, 0, 1, 8, 0);
    #1;
    checks++;
    if (intf.stall_o !== 1'b1) begin failures++; $display("FAIL rs_prestall got=%b exp=1", intf.stall_o); end
    intf.redirect_i = 1'b1;
    #1;
    checks++;
    if (intf.stall_o !== 1'b0 || intf.flush_o !== 1'b1) begin
      failures++; $display("FAIL rs_override got=stall%b/flush%b exp=stall0/flush1", intf.stall_o, intf.flush_o);
    end
    tick();
    intf.redirect_i = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (intf.inflight_o !== 3'b000) begin failures++; $display("FAIL rs_discard got=%b exp=000", intf.inflight_o); end
  endtask

  task automatic test_reset_mid_stall();
    clear_pipe();
    set_dec(1, 0, 0, 0, 0, 1, 7, 1);
    tick();
    set_dec(1, 7, 0, 1, 0, 1, 8, 0);
    #1;
    checks++;
    if (intf.stall_o !== 1'b1) begin failures++; $display("FAIL rst_prestall got=%b exp=1", intf.stall_o); end
    #1;
    reset = 1'b0;
    intf.redirect_i = 1'b1;
    #1;
    checks++;
    if (intf.stall_o !== 1'b0 || intf.flush_o !== 1'b0) begin
      failures++; $display("FAIL rst_async got=stall%b/flush%b exp=0/0", intf.stall_o, intf.flush_o);
    end
    checks++;
    if (intf.inflight_o !== 3'b000 || intf.fwd_sel0_o !== 2'd0) begin
      failures++; $display("FAIL rst_clear got=%b/sel%0d exp=000/sel0", intf.inflight_o, intf.fwd_sel0_o);
    end
    intf.redirect_i = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (intf.stall_o !== 1'b0) begin failures++; $display("FAIL rst_residual got=%b exp=0", intf.stall_o); end
    tick();
    #1;
    checks++;
    if (intf.inflight_o !== 3'b001) begin failures++; $display("FAIL rst_issue got=%b exp=001", intf.inflight_o); end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    clear_pipe();
    #1;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    repeat (5) begin
      set_dec(1, 0, 0, 0, 0, 1, 7, 1);
      tick();
      set_dec(1, 7, 0, 1, 0, 1, 8, 0);
      tick();
      tick();
    end
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    intf.redirect_i = 1'b1;
    tick();
    tick();
    intf.redirect_i = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 32'd5) begin failures++; $display("FAIL perf_stall got=%0d exp=5", stall_cnt); end
    checks++;
    if (flush_cnt !== 32'd2) begin failures++; $display("FAIL perf_flush got=%0d exp=2", flush_cnt); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_alu_chain();
    test_youngest();
    test_load_use();
    test_x0();
    test_redirect();
    test_redirect_stall();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard/forwarding controller for the pipelined RV core; next generation of the five-stage top, which has no hazard handling.
- Tracks in-flight register writers in a shift-register scoreboard, one entry per post-decode stage (EX, MEM, WB by default).
- Sits beside decode and produces operand-forwarding selects, load-use stall and branch-redirect flush.
- Depth, load-ready point and branch-resolve point are parameters, so deeper pipelines reuse it unchanged.

Parameters:
- ADDR_W, 5, register-file address width.
- FWD_DEPTH, 3, number of tracked stages after decode; entry 0 = EX, entry FWD_DEPTH-1 = last stage before RF write. Legal range 2..8.
- LOAD_READY, 1, lowest entry index at which load data is forwardable. Legal range 1..FWD_DEPTH-1.
- BR_STAGE, 1, entry index where branches resolve (MEM). Legal range 0..FWD_DEPTH-1.
- Localparam SEL_W = $clog2(FWD_DEPTH+1).

Ports:
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- dec_valid_i  in  1  decode holds a valid instruction.
- dec_rs0_i  in  ADDR_W  source 0 address.
- dec_rs1_i  in  ADDR_W  source 1 address.
- dec_use_rs0_i  in  1  instruction reads rs0.
- dec_use_rs1_i  in  1  instruction reads rs1.
- dec_rf_we_i  in  1  instruction writes RF.
- dec_waddr_i  in  ADDR_W  destination address.
- dec_is_load_i  in  1  result comes from memory (mem2rf).
- redirect_i  in  1  branch taken at entry BR_STAGE (pc_src).
- stall_o  out  1  hold fetch/decode registers, insert bubble into EX.
- flush_o  out  1  squash fetch/decode/EX pipeline registers.
- fwd_sel0_o  out  SEL_W  0 = RF data; k = result of entry k-1.
- fwd_sel1_o  out  SEL_W  as fwd_sel0_o for source 1.
- inflight_o  out  FWD_DEPTH  valid bit of each scoreboard entry.

Behaviour:
- Scoreboard entry = {valid, waddr, is_load}.
- Reset (reset=0, async): all entries invalid. inflight_o=0, stall_o=0, flush_o=0, fwd_sel*=0 regardless of inputs.
- Issue condition: issue = dec_valid_i & ~stall_o & ~redirect_i.
- Entry-0 write on issue: valid = dec_rf_we_i & (dec_waddr_i != 0); waddr and is_load captured.
- Every cycle: entry k <= entry k-1 for k>=1; entry 0 <= issue entry if issue, else bubble (invalid).
- Oldest entry drops out each cycle; no backpressure from later stages.
- Match rule: source s matches entry k if use_s & valid_k & waddr_k==rs_s & rs_s!=0.
- Youngest (lowest-k) match wins.
- Forward select: fwd_sel_s = k+1 for the winning match, else 0. Combinational, same-cycle.
- Load-use: winning match is_load with k < LOAD_READY -> stall_o=1, and that source's fwd_sel is don't-care.
- Stall persists until the load reaches LOAD_READY; default gives exactly 1 bubble.
- Redirect: redirect_i=1 -> flush_o=1 same cycle, stall_o forced 0 (redirect beats stall).
- On redirect, entries with index < BR_STAGE are squashed as they shift: entry k+1 <= invalid for k < BR_STAGE, and entry 0 <= bubble.
- The branch entry and older entries shift normally.
- Redirect while stalling: stall dropped, flush wins, the stalled decode instruction is discarded.
- x0 never tracked and never matched.
- Both sources matching the same entry: both selects point to it.
- Back-to-back redirects are each handled independently.
- Reset asserted mid-stall or mid-flush clears everything immediately; no residual stall after release.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
- stall_cnt_o increments each cycle stall_o=1; flush_cnt_o increments each cycle flush_o=1.
- Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- ALU chain: issue add x5 then add x6,x5,x5 next cycle -> fwd_sel0=fwd_sel1=1, stall_o=0. Two cycles later a reader of x5 gets fwd_sel=3.
- Load-use: lw x7 then add x8,x7,x1 -> stall_o=1 for exactly 1 cycle, then fwd_sel0=2. inflight_o shows the bubble (3'b101 after shift).
- x0 writer: issue addi x0 then read x0 -> inflight_o bit0=0, fwd_sel0=0, no stall.
- Redirect: x3 writers in entries 0..2, redirect_i=1 -> flush_o=1, stall_o=0. Next cycle entry0 and entry1 invalid, entry2 holds the branch-stage entry.
- Redirect during load-use stall -> stall_o=0 that cycle, stalled instruction not issued, no x7 reader in entry 0 afterwards.
- Reset pulse (0 for 1 cycle, async mid-cycle) during stall -> all outputs 0 immediately.
- With HAZARD_PERF_CNT_EN: 5 stalls and 2 flushes -> stall_cnt_o=5, flush_cnt_o=2.
